// File: rtl/puf_resp_gen_pkg.sv
// Shared types and helpers for the PUF response generator.
package puf_resp_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MEAS,
        ST_GAP,
        ST_CMP,
        ST_OUT
    } state_t;

    // Width of the measurement index: two measurements per response bit.
    function automatic int chal_width(input int n_bits);
        return $clog2(2 * n_bits);
    endfunction

endpackage

// File: rtl/puf_timeout_cnt.sv
// Measurement watchdog: counts cycles while running, flags the last allowed cycle.
module puf_timeout_cnt #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_run,
    output logic o_expired
);

    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt;

    // Cycle counter, held at zero whenever the owner is not measuring.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst || i_clr) begin
            cnt <= '0;
        end else if (i_run && (cnt != LAST)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Expiry lands on the TIMEOUT-th running cycle.
    assign o_expired = i_run && (cnt == LAST);

endmodule

// File: rtl/puf_resp_gen.sv
// PUF response generator: measures ring-oscillator counts in pairs and packs
// one comparison bit per pair into a response word.
module puf_resp_gen
    import puf_resp_gen_pkg::*;
#(
    parameter int  CNT_BIT_SIZE = 5,
    parameter int  N_BITS       = 8,
    parameter int  GAP          = 2,
    parameter int  TIMEOUT      = 1024,
    localparam int CW           = chal_width(N_BITS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic                    i_puf_valid,
    input  logic [CNT_BIT_SIZE-1:0] i_puf_count,
    output logic                    o_puf_en,
    output logic [CW-1:0]           o_challenge,
    output logic [N_BITS-1:0]       o_resp,
    output logic                    o_resp_valid,
    input  logic                    i_resp_ready,
    output logic                    o_busy,
    output logic                    o_err,
    output logic                    o_tie
);

    localparam int GW = $clog2(GAP + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(2 * N_BITS - 1);

    state_t                  state_q;
    state_t                  state_d;
    logic [CNT_BIT_SIZE-1:0] reg_a;
    logic [CNT_BIT_SIZE-1:0] reg_b;
    logic                    valid_q;
    logic                    valid_edge;
    logic [GW-1:0]           gap_cnt;
    logic                    gap_done;
    logic                    expired;

    assign valid_edge = i_puf_valid && !valid_q;
    assign gap_done   = (gap_cnt == GAP_LAST);

    puf_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (state_q != ST_MEAS),
        .i_run     (state_q == ST_MEAS),
        .o_expired (expired)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state decode.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch forms.
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (i_start) state_d = ST_MEAS;
            ST_MEAS: begin
                if (valid_edge)   state_d = ST_GAP;
                else if (expired) state_d = ST_IDLE;
            end
            ST_GAP:  if (gap_done) state_d = o_challenge[0] ? ST_CMP : ST_MEAS;
            ST_CMP:  state_d = (o_challenge == LAST_IDX) ? ST_OUT : ST_MEAS;
            ST_OUT:  if (i_resp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Gap length counter, restarted on every GAP entry.
    always_ff @(posedge clk) begin
        if (rst || (state_q != ST_GAP)) gap_cnt <= '0;
        else if (!gap_done)             gap_cnt <= gap_cnt + 1'b1;
    end

    // Measurement capture, index stepping, bit compare and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_challenge <= '0;
            o_resp      <= '0;
            o_err       <= 1'b0;
            o_tie       <= 1'b0;
            reg_a       <= '0;
            reg_b       <= '0;
            valid_q     <= 1'b0;
        end else begin
            valid_q <= i_puf_valid;
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        o_challenge <= '0;
                        o_resp      <= '0;
                        o_err       <= 1'b0;
                        o_tie       <= 1'b0;
                    end
                end
                ST_MEAS: begin
                    if (valid_edge) begin
                        if (o_challenge[0]) reg_b <= i_puf_count;
                        else                reg_a <= i_puf_count;
                    end else if (expired) begin
                        o_err <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_done && !o_challenge[0]) o_challenge <= o_challenge + 1'b1;
                end
                ST_CMP: begin
                    // Shift right so pair k settles at bit k after the last pair.
                    o_resp <= {(reg_a > reg_b), o_resp[N_BITS-1:1]};
                    if (reg_a == reg_b) o_tie <= 1'b1;
                    if (o_challenge != LAST_IDX) o_challenge <= o_challenge + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // State-decoded outputs, registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_puf_en     <= 1'b0;
            o_busy       <= 1'b0;
            o_resp_valid <= 1'b0;
        end else begin
            o_puf_en     <= (state_d == ST_MEAS);
            o_busy       <= (state_d != ST_IDLE);
            o_resp_valid <= (state_d == ST_OUT);
        end
    end

endmodule

// File: tb/tb_puf_resp_gen.sv
// Scoreboard bench for puf_resp_gen (N_BITS=4, GAP=2, CNT_BIT_SIZE=5, TIMEOUT=64).
module tb_puf_resp_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_start;
    logic       i_puf_valid;
    logic [4:0] i_puf_count;
    logic       o_puf_en;
    logic [2:0] o_challenge;
    logic [3:0] o_resp;
    logic       o_resp_valid;
    logic       i_resp_ready;
    logic       o_busy;
    logic       o_err;
    logic       o_tie;

    typedef struct packed {
        logic [3:0] resp;
        logic       tie;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   n_seen = 0;

    puf_resp_gen #(
        .CNT_BIT_SIZE (5),
        .N_BITS       (4),
        .GAP          (2),
        .TIMEOUT      (64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_puf_valid  (i_puf_valid),
        .i_puf_count  (i_puf_count),
        .o_puf_en     (o_puf_en),
        .o_challenge  (o_challenge),
        .o_resp       (o_resp),
        .o_resp_valid (o_resp_valid),
        .i_resp_ready (i_resp_ready),
        .o_busy       (o_busy),
        .o_err        (o_err),
        .o_tie        (o_tie)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_en(input logic lvl, input string name);
        int n = 0;
        while (o_puf_en !== lvl && n < 200) begin
            tick();
            n++;
        end
        if (o_puf_en !== lvl) bound_fail(name);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (o_busy !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        if (o_busy !== 1'b0) bound_fail(name);
    endtask

    task automatic start_word();
        tick();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    // One measurement as the upstream counter would deliver it.
    task automatic measure(input int idx, input logic [4:0] cnt, input int dly);
        wait_en(1'b1, "wait_en_high");
        check($sformatf("challenge_%0d", idx), 32'(o_challenge), 32'(idx));
        repeat (dly) tick();
        i_puf_count = cnt;
        i_puf_valid = 1'b1;
        wait_en(1'b0, "wait_en_low");
        i_puf_valid = 1'b0;
    endtask

    // Counts packed as {c7,...,c0}; runs measurements first..last.
    task automatic run_meas(input logic [39:0] v, input int first, input int last);
        for (int k = first; k <= last; k++) measure(k, v[k*5 +: 5], k % 3);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_puf_en"},     32'(o_puf_en),     32'd0);
        check({tag, "_challenge"},  32'(o_challenge),  32'd0);
        check({tag, "_resp"},       32'(o_resp),       32'd0);
        check({tag, "_resp_valid"}, 32'(o_resp_valid), 32'd0);
        check({tag, "_busy"},       32'(o_busy),       32'd0);
        check({tag, "_err"},        32'(o_err),        32'd0);
        check({tag, "_tie"},        32'(o_tie),        32'd0);
    endtask

    // Monitor: every accepted response is popped against the scoreboard.
    always @(negedge clk) begin
        if (!rst && o_resp_valid && i_resp_ready) begin
            n_seen++;
            if (sb.size() == 0) begin
                bound_fail("unexpected_resp");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("mon_resp", 32'(o_resp), 32'(e.resp));
                check("mon_tie",  32'(o_tie),  32'(e.tie));
                check("mon_err",  32'(o_err),  32'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        rst          = 1'b1;
        i_start      = 1'b0;
        i_puf_valid  = 1'b0;
        i_puf_count  = '0;
        i_resp_ready = 1'b1;
        repeat (3) tick();
        check_reset_outs("reset");
        rst = 1'b0;

        // Word A: 20,10,5,9,17,17,31,0 -> 1001 with a tie.
        sb.push_back('{resp: 4'b1001, tie: 1'b1});
        start_word();
        run_meas({5'd0, 5'd31, 5'd17, 5'd17, 5'd9, 5'd5, 5'd10, 5'd20}, 0, 7);
        wait_idle("idle_a");
        check("a_err", 32'(o_err), 32'd0);

        // Word B with the sink stalled: 3,2,2,3,9,1,0,0 -> 0101, tie.
        i_resp_ready = 1'b0;
        sb.push_back('{resp: 4'b0101, tie: 1'b1});
        start_word();
        run_meas({5'd0, 5'd0, 5'd1, 5'd9, 5'd3, 5'd2, 5'd2, 5'd3}, 0, 7);
        n = 0;
        while (o_resp_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (o_resp_valid !== 1'b1) bound_fail("wait_valid_b");
        for (int i = 0; i < 10; i++) begin
            check("stall_valid", 32'(o_resp_valid), 32'd1);
            check("stall_resp",  32'(o_resp),       32'h5);
            tick();
        end
        i_resp_ready = 1'b1;
        tick();
        check("b_valid_dropped", 32'(o_resp_valid), 32'd0);
        check("b_idle",          32'(o_busy),       32'd0);

        // Word C back-to-back: 1,0,0,1,2,3,4,3 -> 1001, no tie.
        sb.push_back('{resp: 4'b1001, tie: 1'b0});
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("c_tie_cleared", 32'(o_tie),       32'd0);
        check("c_busy",        32'(o_busy),      32'd1);
        check("c_challenge",   32'(o_challenge), 32'd0);
        run_meas({5'd3, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0, 5'd0, 5'd1}, 0, 7);
        wait_idle("idle_c");

        // Timeout at index 3: no valid edge for 64 cycles.
        start_word();
        run_meas({5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd2, 5'd1}, 0, 2);
        wait_en(1'b1, "wait_en_to");
        check("to_challenge", 32'(o_challenge), 32'd3);
        n = 0;
        while (o_busy !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        check("to_cycles",     32'(n),            32'd64);
        check("to_err",        32'(o_err),        32'd1);
        check("to_puf_en",     32'(o_puf_en),     32'd0);
        check("to_resp_valid", 32'(o_resp_valid), 32'd0);

        // Word E: valid already high on entry; only the later rise captures 7.
        sb.push_back('{resp: 4'b1000, tie: 1'b1});
        i_puf_count = 5'd30;
        i_puf_valid = 1'b1;
        start_word();
        check("e_err_cleared", 32'(o_err), 32'd0);
        repeat (5) tick();
        check("e_still_meas", 32'(o_puf_en),    32'd1);
        check("e_still_idx0", 32'(o_challenge), 32'd0);
        i_puf_valid = 1'b0;
        tick();
        i_puf_count = 5'd7;
        i_puf_valid = 1'b1;
        wait_en(1'b0, "wait_en_low_e");
        i_puf_valid = 1'b0;
        run_meas({5'd8, 5'd9, 5'd1, 5'd0, 5'd2, 5'd2, 5'd8, 5'd0}, 1, 7);
        wait_idle("idle_e");

        // Reset during GAP at index 5, then a clean word: 4,4,10,3,0,31,16,15 -> 1010.
        start_word();
        run_meas({5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd10, 5'd4, 5'd4}, 0, 4);
        wait_en(1'b1, "wait_en_r5");
        check("r_challenge5", 32'(o_challenge), 32'd5);
        i_puf_count = 5'd31;
        i_puf_valid = 1'b1;
        wait_en(1'b0, "wait_gap_r5");
        rst = 1'b1;
        tick();
        check_reset_outs("midrst");
        rst         = 1'b0;
        i_puf_valid = 1'b0;
        sb.push_back('{resp: 4'b1010, tie: 1'b1});
        start_word();
        check("f_challenge0", 32'(o_challenge), 32'd0);
        run_meas({5'd15, 5'd16, 5'd31, 5'd0, 5'd3, 5'd10, 5'd4, 5'd4}, 0, 7);
        wait_idle("idle_f");

        repeat (5) tick();
        check("resp_count", 32'(n_seen),    32'd5);
        check("sb_empty",   32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/puf_resp_gen.md
PUF_RESP_GEN -- requirements
Module: puf_resp_gen

Interface
REQ-001 Parameter CNT_BIT_SIZE, default 5: width of the upstream count.
REQ-002 Parameter N_BITS, default 8: response bits per word.
REQ-003 Parameter GAP, default 2: o_puf_en low cycles between measurements (min 1).
REQ-004 Parameter TIMEOUT, default 1024: max cycles waiting for valid per measurement.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 i_start  in  1  request one response word; sampled only in IDLE.
REQ-008 i_puf_valid  in  1  upstream counter valid, level.
REQ-009 i_puf_count  in  CNT_BIT_SIZE  upstream count value.
REQ-010 o_puf_en  out  1  enable to the PUF ring oscillator and counter.
REQ-011 o_challenge  out  clog2(2*N_BITS)  index of the current measurement.
REQ-012 o_resp  out  N_BITS  response word, bit 0 from the first pair.
REQ-013 o_resp_valid  out  1  o_resp is valid; held until accepted.
REQ-014 i_resp_ready  in  1  downstream accepts on o_resp_valid & i_resp_ready.
REQ-015 o_busy  out  1  high in any state except IDLE.
REQ-016 o_err  out  1  timeout flag; sticky until the next accepted i_start.
REQ-017 o_tie  out  1  at least one pair had equal counts in this word.

Function
REQ-018 FSM states are IDLE, MEAS, GAP, CMP and OUT.
- IDLE -> MEAS on i_start; clears o_err, o_tie, measurement index and the bit shift register.
REQ-019 MEAS drives o_puf_en=1 and detects a 0->1 edge of i_puf_valid using a registered copy of it.
- On the edge: capture i_puf_count into regA (even index) or regB (odd index), then go to GAP.
REQ-020 i_puf_valid already high on MEAS entry is not an edge; it is ignored until it falls and rises again.
REQ-021 GAP drives o_puf_en=0 for exactly GAP cycles.
- Then: CMP if the index is odd, otherwise MEAS with the index incremented.
REQ-022 CMP lasts one cycle.
- Response bit = (regA > regB), unsigned compare over CNT_BIT_SIZE bits.
- regA == regB gives bit 0 and sets o_tie.
- The bit shifts in so that pair k lands at o_resp[k].
REQ-023 After CMP: if pair N_BITS-1 is done, go to OUT; otherwise go to MEAS with the index incremented.
REQ-024 OUT asserts o_resp_valid, with o_resp stable.
- Transfer on valid & ready; the next state is IDLE.
- i_start in OUT is ignored.
REQ-025 Timeout: the timeout counter runs only in MEAS and restarts at every MEAS entry.
- If TIMEOUT cycles pass with no valid edge: set o_err and go to IDLE with o_puf_en=0.
- No o_resp_valid is raised for that word.
REQ-026 o_challenge equals the measurement index, 0..2*N_BITS-1; it is held through GAP and CMP.
REQ-027 Latency per word = sum of MEAS waits + 2*N_BITS*GAP + N_BITS (CMP) + 1 cycle to OUT.

Reset
REQ-028 rst forces IDLE in the same edge, including mid-measurement and in OUT.
REQ-029 Reset values: o_puf_en=0, o_resp=0, o_resp_valid=0, o_busy=0, o_err=0, o_tie=0, o_challenge=0.
- Internal counters, regA, regB and the valid-edge register reset to 0.

Structure
REQ-030 A shared package holds the FSM state enumeration and the width function for o_challenge.
REQ-031 The timeout counter is the single sub-module, puf_timeout_cnt, with ports clk, rst, i_clr, i_run and o_expired.
REQ-032 All outputs are registered; there is no combinational path from any input to any output.

Verification (N_BITS=4, GAP=2, CNT_BIT_SIZE=5, TIMEOUT=64)
REQ-033 Counts 20,10,5,9,17,17,31,0 -> o_resp=4'b1001, o_tie=1, o_err=0, one o_resp_valid.
REQ-034 i_resp_ready held low 10 cycles in OUT -> o_resp_valid and o_resp stable, then one transfer and IDLE.
REQ-035 No valid edge for 64 cycles at index 3 -> o_err=1, o_puf_en=0, IDLE, no o_resp_valid.
REQ-036 i_puf_valid already high at MEAS entry -> no capture until it falls and rises again.
REQ-037 rst pulsed during GAP at index 5 -> all outputs at reset values next cycle; the next i_start begins at index 0.
REQ-038 Back-to-back words, with i_start asserted on the cycle after the transfer -> the second word starts cleanly and the o_tie/o_err from the first word are cleared.
